// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  localparam int BYTE_W = 8;
  localparam int BAUD_W = 3;
  localparam logic [BAUD_W-1:0] BAUD_DEFAULT = 3'd0;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } rx_state_e;

  function automatic logic rise(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead byte FIFO; a push into a full FIFO only lands when a pop frees a slot the same cycle.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [BYTE_W-1:0]        wdata,
  output logic [BYTE_W-1:0]        rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [BYTE_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       count_r;
  logic              do_push_s;
  logic              do_pop_s;

  // qualify push/pop against occupancy
  always_comb begin
    do_pop_s  = pop & (count_r != '0);
    do_push_s = push & ((count_r != FULL_CNT) | do_pop_s);
  end

  // storage, pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign empty = (count_r == '0);
  assign full  = (count_r == FULL_CNT);
  assign count = count_r;

endmodule

// File: rtl/uart_rx_controller.sv
// Sequences uart_receiver (enable, baud code), buffers received bytes and keeps sticky error status.
// Optional UART_RX_ERR_COUNT_EN adds saturating parity/framing error counters.
module uart_rx_controller
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int GUARD_CYCLES = 16
`ifdef UART_RX_ERR_COUNT_EN
  , parameter int ERR_CNT_W  = 8
`endif
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          host_enable,
  input  logic                          cfg_wr,
  input  logic [BAUD_W-1:0]             cfg_baud,
  output logic                          cfg_rej,
  output logic [BAUD_W-1:0]             baud_select,
  output logic                          rx_en,
  input  logic [BYTE_W-1:0]             rx_data,
  input  logic                          rx_valid,
  input  logic                          rx_perror,
  input  logic                          rx_ferror,
  output logic [BYTE_W-1:0]             rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  output logic                          perr_flag,
  output logic                          ferr_flag,
  input  logic                          err_clr,
  output logic                          busy
`ifdef UART_RX_ERR_COUNT_EN
  ,
  output logic [ERR_CNT_W-1:0]          perr_cnt,
  output logic [ERR_CNT_W-1:0]          ferr_cnt
`endif
);

  localparam int QW = $clog2(GUARD_CYCLES + 1);
  localparam logic [QW-1:0] GUARD_LOAD = QW'(GUARD_CYCLES - 1);

  rx_state_e         state_r, state_nxt_s;
  logic [QW-1:0]     quiet_r, quiet_nxt_s;
  logic              valid_d_r, perr_d_r, ferr_d_r;
  logic              valid_edge_s, perr_edge_s, ferr_edge_s, any_edge_s;
  logic              push_s, pop_s, overrun_set_s;
  logic              fifo_empty_s, fifo_full_s;
  logic              rx_en_r, busy_r, cfg_rej_r;
  logic [BAUD_W-1:0] baud_r;
  logic              overrun_r, perr_flag_r, ferr_flag_r;

  // edge detection and FIFO handshake qualification
  always_comb begin
    valid_edge_s  = rise(rx_valid, valid_d_r);
    perr_edge_s   = rise(rx_perror, perr_d_r);
    ferr_edge_s   = rise(rx_ferror, ferr_d_r);
    any_edge_s    = valid_edge_s | perr_edge_s | ferr_edge_s;
    push_s        = valid_edge_s & (state_r != OFF);
    pop_s         = ~fifo_empty_s & rd_ready;
    overrun_set_s = push_s & fifo_full_s & ~pop_s;
  end

  // next state; STOP waits for GUARD_CYCLES quiet cycles, any receiver edge restarts the wait
  always_comb begin
    state_nxt_s = state_r;
    quiet_nxt_s = quiet_r;
    case (state_r)
      OFF: begin
        if (host_enable) state_nxt_s = RUN;
        else             state_nxt_s = OFF;
      end
      RUN: begin
        if (!host_enable) begin
          state_nxt_s = STOP;
          quiet_nxt_s = GUARD_LOAD;
        end else begin
          state_nxt_s = RUN;
        end
      end
      STOP: begin
        if (host_enable)           state_nxt_s = RUN;
        else if (any_edge_s)       quiet_nxt_s = GUARD_LOAD;
        else if (quiet_r == '0)    state_nxt_s = OFF;
        else                       quiet_nxt_s = quiet_r - QW'(1);
      end
      default: state_nxt_s = OFF;
    endcase
  end

  // state register with registered rx_en/busy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= OFF;
      quiet_r <= '0;
      rx_en_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      quiet_r <= quiet_nxt_s;
      rx_en_r <= (state_nxt_s == RUN);
      busy_r  <= (state_nxt_s != OFF);
    end
  end

  // baud config register, writes only accepted while OFF
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_r    <= BAUD_DEFAULT;
      cfg_rej_r <= 1'b0;
    end else begin
      cfg_rej_r <= cfg_wr & (state_r != OFF);
      if (cfg_wr && (state_r == OFF)) baud_r <= cfg_baud;
    end
  end

  // one-cycle delayed copies for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_d_r <= 1'b0;
      perr_d_r  <= 1'b0;
      ferr_d_r  <= 1'b0;
    end else begin
      valid_d_r <= rx_valid;
      perr_d_r  <= rx_perror;
      ferr_d_r  <= rx_ferror;
    end
  end

`ifdef UART_RX_ERR_COUNT_EN
  logic [ERR_CNT_W-1:0] perr_cnt_r, ferr_cnt_r;

  // sticky flags and saturating counters; an error edge beats err_clr
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_r   <= 1'b0;
      perr_flag_r <= 1'b0;
      ferr_flag_r <= 1'b0;
      perr_cnt_r  <= '0;
      ferr_cnt_r  <= '0;
    end else begin
      overrun_r   <= overrun_set_s | (overrun_r & ~err_clr);
      perr_flag_r <= perr_edge_s | (perr_flag_r & ~err_clr);
      ferr_flag_r <= ferr_edge_s | (ferr_flag_r & ~err_clr);
      if (perr_edge_s && err_clr)      perr_cnt_r <= ERR_CNT_W'(1);
      else if (err_clr)                perr_cnt_r <= '0;
      else if (perr_edge_s && (perr_cnt_r != '1)) perr_cnt_r <= perr_cnt_r + ERR_CNT_W'(1);
      if (ferr_edge_s && err_clr)      ferr_cnt_r <= ERR_CNT_W'(1);
      else if (err_clr)                ferr_cnt_r <= '0;
      else if (ferr_edge_s && (ferr_cnt_r != '1)) ferr_cnt_r <= ferr_cnt_r + ERR_CNT_W'(1);
    end
  end

  assign perr_cnt = perr_cnt_r;
  assign ferr_cnt = ferr_cnt_r;
`else
  // sticky flags; an error edge beats err_clr
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_r   <= 1'b0;
      perr_flag_r <= 1'b0;
      ferr_flag_r <= 1'b0;
    end else begin
      overrun_r   <= overrun_set_s | (overrun_r & ~err_clr);
      perr_flag_r <= perr_edge_s | (perr_flag_r & ~err_clr);
      ferr_flag_r <= ferr_edge_s | (ferr_flag_r & ~err_clr);
    end
  end
`endif

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (rx_data),
    .rdata (rd_data),
    .empty (fifo_empty_s),
    .full  (fifo_full_s),
    .count (fifo_count)
  );

  assign rd_valid    = ~fifo_empty_s;
  assign rx_en       = rx_en_r;
  assign busy        = busy_r;
  assign cfg_rej     = cfg_rej_r;
  assign baud_select = baud_r;
  assign overrun     = overrun_r;
  assign perr_flag   = perr_flag_r;
  assign ferr_flag   = ferr_flag_r;

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed self-checking bench for uart_rx_controller (FIFO_DEPTH=4, GUARD_CYCLES=16).
module tb_uart_rx_controller;

  localparam int G = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       host_enable, cfg_wr, cfg_rej, rx_en, rx_valid, rx_perror, rx_ferror;
  logic [2:0] cfg_baud, baud_select;
  logic [7:0] rx_data, rd_data;
  logic       rd_valid, rd_ready, overrun, perr_flag, ferr_flag, err_clr, busy;
  logic [2:0] fifo_count;
`ifdef UART_RX_ERR_COUNT_EN
  logic [7:0] perr_cnt, ferr_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  uart_rx_controller dut (
    .clk(clk), .reset(reset), .host_enable(host_enable), .cfg_wr(cfg_wr),
    .cfg_baud(cfg_baud), .cfg_rej(cfg_rej), .baud_select(baud_select), .rx_en(rx_en),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_perror(rx_perror), .rx_ferror(rx_ferror),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .fifo_count(fifo_count),
    .overrun(overrun), .perr_flag(perr_flag), .ferr_flag(ferr_flag), .err_clr(err_clr),
    .busy(busy)
`ifdef UART_RX_ERR_COUNT_EN
    , .perr_cnt(perr_cnt), .ferr_cnt(ferr_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    step();
  endtask

  task automatic drain(input logic [7:0] exp [4], input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      check({tag, "_valid"}, 32'(rd_valid), 32'd1);
      check({tag, "_data"}, 32'(rd_data), 32'(exp[i]));
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
    end
    check({tag, "_empty"}, 32'(rd_valid), 32'd0);
  endtask

  logic [7:0] exp_q [4];

  initial begin
    reset = 1'b1; host_enable = 1'b0; cfg_wr = 1'b0; cfg_baud = 3'd0;
    rx_data = 8'h00; rx_valid = 1'b0; rx_perror = 1'b0; rx_ferror = 1'b0;
    rd_ready = 1'b0; err_clr = 1'b0;
    step(); step();
    reset = 1'b0;
    step();
    check("rst_rx_en", 32'(rx_en), 32'd0);
    check("rst_baud", 32'(baud_select), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flags", 32'({overrun, perr_flag, ferr_flag, cfg_rej}), 32'd0);

    // 1: configuration
    cfg_wr = 1'b1; cfg_baud = 3'd5;
    step();
    cfg_wr = 1'b0;
    check("cfg_baud_off", 32'(baud_select), 32'd5);
    check("cfg_rej_off", 32'(cfg_rej), 32'd0);
    host_enable = 1'b1;
    step();
    check("run_rx_en", 32'(rx_en), 32'd1);
    check("run_busy", 32'(busy), 32'd1);
    cfg_wr = 1'b1; cfg_baud = 3'd2;
    step();
    cfg_wr = 1'b0;
    check("cfg_rej_run", 32'(cfg_rej), 32'd1);
    check("cfg_baud_run", 32'(baud_select), 32'd5);
    step();
    check("cfg_rej_pulse", 32'(cfg_rej), 32'd0);

    // 2: ordered buffering
    rx_data = 8'hA5; rx_valid = 1'b1;
    step();
    check("first_rd_valid", 32'(rd_valid), 32'd1);
    rx_valid = 1'b0;
    step();
    send_byte(8'h3C);
    send_byte(8'hFF);
    check("t2_count", 32'(fifo_count), 32'd3);
    exp_q = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    drain(exp_q, 3, "t2");
    check("t2_count0", 32'(fifo_count), 32'd0);

    // 3: overrun, then full push+pop
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
    check("t3_count", 32'(fifo_count), 32'd4);
    check("t3_overrun", 32'(overrun), 32'd1);
    check("t3_head", 32'(rd_data), 32'h11);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("t3_ovr_clr", 32'(overrun), 32'd0);
    rx_data = 8'h66; rx_valid = 1'b1; rd_ready = 1'b1;
    step();
    rx_valid = 1'b0; rd_ready = 1'b0;
    check("t3_pp_count", 32'(fifo_count), 32'd4);
    check("t3_pp_ovr", 32'(overrun), 32'd0);
    step();
    exp_q = '{8'h22, 8'h33, 8'h44, 8'h66};
    drain(exp_q, 4, "t3");

    // 4: error edges and err_clr priority
    rx_perror = 1'b1;
    step(); step(); step();
    rx_perror = 1'b0;
    check("t4_perr", 32'(perr_flag), 32'd1);
    check("t4_ferr0", 32'(ferr_flag), 32'd0);
    check("t4_no_push", 32'(fifo_count), 32'd0);
`ifdef UART_RX_ERR_COUNT_EN
    check("t4_perr_cnt", 32'(perr_cnt), 32'd1);
`endif
    err_clr = 1'b1; rx_ferror = 1'b1;
    step();
    err_clr = 1'b0; rx_ferror = 1'b0;
    check("t4_perr_clr", 32'(perr_flag), 32'd0);
    check("t4_ferr_win", 32'(ferr_flag), 32'd1);
`ifdef UART_RX_ERR_COUNT_EN
    check("t4_ferr_cnt", 32'(ferr_cnt), 32'd1);
    check("t4_perr_cnt0", 32'(perr_cnt), 32'd0);
`endif

    // 5: STOP guard timing
    host_enable = 1'b0;
    step();
    check("t5_rx_en0", 32'(rx_en), 32'd0);
    check("t5_busy_stop", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) step();
    rx_data = 8'h77; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    check("t5_stored", 32'(fifo_count), 32'd1);
    check("t5_data", 32'(rd_data), 32'h77);
    for (int i = 0; i < G - 1; i++) step();
    check("t5_busy_before", 32'(busy), 32'd1);
    step();
    check("t5_off", 32'(busy), 32'd0);
    check("t5_rx_en_off", 32'(rx_en), 32'd0);
    send_byte(8'h88);
    check("t5_off_discard", 32'(fifo_count), 32'd1);

    // 6: async reset mid-STOP
    host_enable = 1'b1;
    step();
    send_byte(8'h99);
    check("t6_count2", 32'(fifo_count), 32'd2);
    rx_perror = 1'b1;
    step();
    rx_perror = 1'b0;
    host_enable = 1'b0;
    step();
    check("t6_in_stop", 32'({busy, rx_en}), 32'b10);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rd_valid", 32'(rd_valid), 32'd0);
    check("t6_count", 32'(fifo_count), 32'd0);
    check("t6_flags", 32'({overrun, perr_flag, ferr_flag}), 32'd0);
    check("t6_rx_en", 32'(rx_en), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_rd_data", 32'(rd_data), 32'h00);
    step();
    reset = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
